// File: rtl/dcache_axi_bridge.sv
// Bridge from the L1 data cache memory port to an AXI4 master: cached reads
// refill a whole line with an INCR burst, uncached reads and all writes are single beats.
module dcache_axi_bridge #(
  parameter int         offset_width = 2,
  parameter logic [3:0] AXI_ID       = 4'd1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [31:0]                        addr_dcache_mem,
  input  logic [31:0]                        dout_dcache_mem,
  input  logic                               dcache_mem_req,
  input  logic                               dcache_mem_wr,
  input  logic                               dcache_mem_SUC,
  input  logic [1:0]                         dcache_mem_size,
  input  logic [3:0]                         dcache_mem_wstrb,
  output logic                               mem_dcache_addrOK,
  output logic                               mem_dcache_dataOK,
  output logic                               mem_dcache_bvalid,
  output logic [32*(1<<offset_width)-1:0]    din_mem_dcache,
  output logic [3:0]                         arid,
  output logic [7:0]                         arlen,
  output logic [2:0]                         arsize,
  output logic [1:0]                         arburst,
  output logic [31:0]                        araddr,
  output logic                               arvalid,
  input  logic                               arready,
  input  logic [31:0]                        rdata,
  input  logic                               rlast,
  input  logic                               rvalid,
  output logic                               rready,
  output logic [3:0]                         awid,
  output logic [7:0]                         awlen,
  output logic [2:0]                         awsize,
  output logic [1:0]                         awburst,
  output logic [31:0]                        awaddr,
  output logic                               awvalid,
  input  logic                               awready,
  output logic [31:0]                        wdata,
  output logic [3:0]                         wstrb,
  output logic                               wlast,
  output logic                               wvalid,
  input  logic                               wready,
  input  logic                               bvalid,
  output logic                               bready,
  input  logic [1:0]                         bresp
);
  localparam int LINE = 1 << offset_width;
  localparam logic [offset_width-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, RD_DONE, WR_AWW, WR_B} state_t;

  state_t                  state_q;
  logic [31:0]             addr_q, data_q;
  logic                    suc_q;
  logic [1:0]              size_q;
  logic [3:0]              wstrb_q;
  logic                    arvalid_q, rready_q, dataok_q;
  logic                    awvalid_q, wvalid_q, bready_q, aw_done_q, w_done_q;
  logic [offset_width-1:0] cnt_q;
  logic [31:0]             line_q [LINE];

  logic                    aw_hs, w_hs, aw_fin, w_fin;
  logic [offset_width-1:0] widx;
  logic                    unused_bresp;

  assign aw_hs  = awvalid_q & awready;
  assign w_hs   = wvalid_q & wready;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;
  // Uncached reads always land in word 0 regardless of the beat count.
  assign widx   = suc_q ? '0 : cnt_q;
  assign unused_bresp = ^bresp;

  assign mem_dcache_addrOK = (state_q == IDLE) & dcache_mem_req;
  assign mem_dcache_dataOK = dataok_q;
  assign mem_dcache_bvalid = (state_q == WR_B) & bvalid;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = suc_q ? 8'd0 : 8'(LINE - 1);
  assign arsize  = suc_q ? {1'b0, size_q} : 3'd2;
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;
  assign wdata   = data_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  generate
    for (genvar gi = 0; gi < LINE; gi++) begin : g_line_out
      assign din_mem_dcache[32*gi +: 32] = line_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      suc_q     <= 1'b0;
      size_q    <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      dataok_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      for (int k = 0; k < LINE; k++) line_q[k] <= '0;
    end else begin
      dataok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dcache_mem_req) begin
            addr_q  <= addr_dcache_mem;
            data_q  <= dout_dcache_mem;
            suc_q   <= dcache_mem_SUC;
            size_q  <= dcache_mem_size;
            wstrb_q <= dcache_mem_wstrb;
            if (dcache_mem_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR_AWW;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        RD_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (rvalid) begin
            line_q[widx] <= rdata;
            cnt_q        <= cnt_q + CNT_ONE;
            if (rlast) begin
              rready_q <= 1'b0;
              dataok_q <= 1'b1;
              state_q  <= RD_DONE;
            end
          end
        end
        RD_DONE: state_q <= IDLE;
        WR_AWW: begin
          // AW and W complete independently; leave only once both are done.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed plus randomized bench for dcache_axi_bridge; an AXI slave is driven
// inline and read results are compared against a word-array line model.
module tb_dcache_axi_bridge;
  localparam int LINE = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  addr_dcache_mem, dout_dcache_mem;
  logic         dcache_mem_req, dcache_mem_wr, dcache_mem_SUC;
  logic [1:0]   dcache_mem_size;
  logic [3:0]   dcache_mem_wstrb;
  logic         mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_bvalid;
  logic [127:0] din_mem_dcache;
  logic [3:0]   arid, awid;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready;
  logic [3:0]   wstrb;
  logic         bvalid, bready;
  logic [1:0]   bresp;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_line [LINE];
  logic [31:0] beat_data [16];

  dcache_axi_bridge #(.offset_width(2), .AXI_ID(4'd1)) dut (
    .clk(clk), .rstn(rstn),
    .addr_dcache_mem(addr_dcache_mem), .dout_dcache_mem(dout_dcache_mem),
    .dcache_mem_req(dcache_mem_req), .dcache_mem_wr(dcache_mem_wr),
    .dcache_mem_SUC(dcache_mem_SUC), .dcache_mem_size(dcache_mem_size),
    .dcache_mem_wstrb(dcache_mem_wstrb),
    .mem_dcache_addrOK(mem_dcache_addrOK), .mem_dcache_dataOK(mem_dcache_dataOK),
    .mem_dcache_bvalid(mem_dcache_bvalid), .din_mem_dcache(din_mem_dcache),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [127:0] model_line();
    logic [127:0] v;
    for (int k = 0; k < LINE; k++) v[32*k +: 32] = exp_line[k];
    return v;
  endfunction

  task automatic do_read(input logic [31:0] a, input logic suc, input logic [1:0] sz,
                         input int nbeats, input int ar_delay, input logic hold);
    dcache_mem_req = 1'b1; dcache_mem_wr = 1'b0; addr_dcache_mem = a;
    dcache_mem_SUC = suc; dcache_mem_size = sz;
    dout_dcache_mem = $urandom; dcache_mem_wstrb = 4'($urandom);
    #1;
    chk("rd_addrOK", mem_dcache_addrOK, 1);
    step();
    if (!hold) dcache_mem_req = 1'b0;
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, a);
    chk("arlen", arlen, suc ? 8'd0 : 8'd3);
    chk("arsize", arsize, suc ? {1'b0, sz} : 3'd2);
    chk("arburst", arburst, 2'b01);
    chk("arid", arid, 4'd1);
    for (int k = 0; k < ar_delay; k++) begin
      step();
      chk("arvalid_hold", arvalid, 1);
      chk("araddr_hold", araddr, a);
      chk("rd_no_addrOK", mem_dcache_addrOK, 0);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("arvalid_drop", arvalid, 0);
    chk("rready", rready, 1);
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("rready_gap", rready, 1);
      end
      rvalid = 1'b1; rdata = beat_data[i]; rlast = (i == nbeats - 1);
      step();
      rvalid = 1'b0; rlast = 1'b0;
      exp_line[suc ? 0 : (i % LINE)] = beat_data[i];
      chk("rd_no_aw", awvalid, 0);
      chk("rd_no_addrOK", mem_dcache_addrOK, 0);
      if (i != nbeats - 1) chk("dataOK_early", mem_dcache_dataOK, 0);
    end
    chk("dataOK", mem_dcache_dataOK, 1);
    chk("rready_done", rready, 0);
    chk("din", din_mem_dcache, model_line());
    step();
    chk("dataOK_pulse", mem_dcache_dataOK, 0);
    chk("din_stable", din_mem_dcache, model_line());
    $display("read  addr=%h suc=%0d size=%0d beats=%0d din=%h", a, suc, sz, nbeats, din_mem_dcache);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ws,
                          input logic [1:0] sz, input int aw_delay, input int w_delay,
                          input int b_delay);
    bit aw_done = 0;
    bit w_done  = 0;
    int c = 0;
    dcache_mem_req = 1'b1; dcache_mem_wr = 1'b1; addr_dcache_mem = a;
    dout_dcache_mem = d; dcache_mem_wstrb = ws; dcache_mem_size = sz;
    dcache_mem_SUC = 1'($urandom);
    #1;
    chk("wr_addrOK", mem_dcache_addrOK, 1);
    step();
    dcache_mem_req = 1'b0;
    while (!(aw_done && w_done)) begin
      if (c > 40) begin
        n_checks++; n_err++;
        $display("FAIL wr_timeout: observed no completion expected both handshakes");
        break;
      end
      chk("awvalid", awvalid, !aw_done);
      chk("wvalid", wvalid, !w_done);
      chk("bready_early", bready, 0);
      if (!aw_done) begin
        chk("awaddr", awaddr, a);
        chk("awlen", awlen, 8'd0);
        chk("awsize", awsize, {1'b0, sz});
        chk("awburst", awburst, 2'b01);
        chk("awid", awid, 4'd1);
      end
      if (!w_done) begin
        chk("wdata", wdata, d);
        chk("wstrb", wstrb, ws);
        chk("wlast", wlast, 1);
      end
      awready = !aw_done && (c >= aw_delay);
      wready  = !w_done && (c >= w_delay);
      step();
      if (awready) aw_done = 1;
      if (wready) w_done = 1;
      awready = 1'b0; wready = 1'b0;
      c++;
    end
    chk("bready", bready, 1);
    chk("awvalid_off", awvalid, 0);
    chk("wvalid_off", wvalid, 0);
    for (int k = 0; k < b_delay; k++) begin
      chk("mem_bvalid_early", mem_dcache_bvalid, 0);
      step();
      chk("bready_hold", bready, 1);
    end
    bresp = 2'($urandom);
    bvalid = 1'b1;
    #1;
    chk("mem_bvalid", mem_dcache_bvalid, 1);
    chk("wr_no_dataOK", mem_dcache_dataOK, 0);
    step();
    bvalid = 1'b0;
    chk("mem_bvalid_pulse", mem_dcache_bvalid, 0);
    chk("bready_drop", bready, 0);
    $display("write addr=%h data=%h wstrb=%b aw_dly=%0d w_dly=%0d", a, d, ws, aw_delay, w_delay);
  endtask

  initial begin
    rstn = 1'b0;
    addr_dcache_mem = '0; dout_dcache_mem = '0; dcache_mem_req = 1'b0;
    dcache_mem_wr = 1'b0; dcache_mem_SUC = 1'b0; dcache_mem_size = '0; dcache_mem_wstrb = '0;
    arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
    for (int k = 0; k < LINE; k++) exp_line[k] = '0;
    repeat (3) step();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_dataOK", mem_dcache_dataOK, 0);
    chk("rst_bvalid", mem_dcache_bvalid, 0);
    chk("rst_din", din_mem_dcache, 128'd0);
    rstn = 1'b1;
    step();

    // Cached line refill
    beat_data[0] = 32'h11; beat_data[1] = 32'h22; beat_data[2] = 32'h33; beat_data[3] = 32'h44;
    do_read(32'h1C000040, 1'b0, 2'd2, 4, 2, 1'b0);
    chk("line_const", din_mem_dcache, 128'h00000044_00000033_00000022_00000011);

    // Uncached byte read touches word 0 only
    beat_data[0] = 32'hAB;
    do_read(32'hBFD003F8, 1'b1, 2'd0, 1, 0, 1'b0);
    chk("suc_const", din_mem_dcache, 128'h00000044_00000033_00000022_000000AB);

    do_write(32'h00001004, 32'hDEADBEEF, 4'b0011, 2'd2, 0, 3, 1);

    // Request held high through a read, followed by a write
    for (int i = 0; i < 4; i++) beat_data[i] = $urandom;
    do_read(32'h00003000, 1'b0, 2'd2, 4, 1, 1'b1);
    do_write(32'h00003010, 32'hCAFEF00D, 4'b1111, 2'd2, 2, 0, 0);

    // Reset in the middle of a refill
    dcache_mem_req = 1'b1; dcache_mem_wr = 1'b0; dcache_mem_SUC = 1'b0;
    addr_dcache_mem = 32'h00004000; dcache_mem_size = 2'd2;
    #1;
    chk("rst_t_addrOK", mem_dcache_addrOK, 1);
    step();
    dcache_mem_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = $urandom; rlast = 1'b0;
      step();
    end
    rvalid = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int k = 0; k < LINE; k++) exp_line[k] = '0;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_din", din_mem_dcache, 128'd0);
    rvalid = 1'b1; rdata = 32'h5555AAAA; rlast = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stray_rready", rready, 0);
      chk("stray_dataOK", mem_dcache_dataOK, 0);
    end
    rvalid = 1'b0; rlast = 1'b0;
    chk("stray_din", din_mem_dcache, 128'd0);
    $display("reset mid-refill: din=%h", din_mem_dcache);
    for (int i = 0; i < 4; i++) beat_data[i] = $urandom;
    do_read(32'h00004000, 1'b0, 2'd2, 4, 0, 1'b0);

    // Short burst leaves words 2-3 intact
    for (int i = 0; i < 2; i++) beat_data[i] = $urandom;
    do_read(32'h00005040, 1'b0, 2'd2, 2, 1, 1'b0);

    // Randomized mix, including overlong bursts that wrap
    for (int t = 0; t < 16; t++) begin
      int op;
      op = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++) beat_data[i] = $urandom;
      case (op)
        0: do_read($urandom & 32'hFFFF_FFF0, 1'b0, 2'd2, $urandom_range(1, 7),
                   $urandom_range(0, 3), 1'b0);
        1: do_read($urandom, 1'b1, 2'($urandom_range(0, 2)), 1, $urandom_range(0, 3), 1'b0);
        default: do_write($urandom, $urandom, 4'($urandom), 2'($urandom_range(0, 2)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
